// File: rtl/mips_pkg.sv
// Shared MIPS decode types: branch modes, forwarding selects, opcode/funct codes, ID/EX control bundle.
package mips_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6
    } branch_mode_t;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ORI    = 6'h0D;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_OR  = 6'h25;

    // Register fields are kept at the full 5-bit instruction width and narrowed at the output.
    typedef struct packed {
        logic       valid;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } id_ex_t;

endpackage

// File: rtl/id_stage_pipelined_if.sv
// ID-stage bus: instruction/forwarding/writeback inputs, branch outputs and the registered ID/EX bundle.
interface id_stage_pipelined_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic             valid_d;
  logic [31:0]      instr_d;
  logic [WIDTH-1:0] pcplus4_d;
  logic             zero_ext_d;
  logic [2:0]       branch_mode_d;
  logic [1:0]       fwd_a_d;
  logic [1:0]       fwd_b_d;
  logic [WIDTH-1:0] alu_out_m;
  logic [WIDTH-1:0] result_w;
  logic [AW-1:0]    write_reg_w;
  logic             reg_write_w;
  logic             stall_d;
  logic             flush_e;
  logic             branch_taken_d;
  logic [WIDTH-1:0] pc_branch_d;
  logic             ex_valid;
  logic [WIDTH-1:0] ex_rd1;
  logic [WIDTH-1:0] ex_rd2;
  logic [WIDTH-1:0] ex_imm;
  logic [AW-1:0]    ex_rs;
  logic [AW-1:0]    ex_rt;
  logic [AW-1:0]    ex_rd;
  logic [5:0]       ex_opcode;
  logic [5:0]       ex_funct;

  modport master (
    output valid_d, instr_d, pcplus4_d, zero_ext_d, branch_mode_d, fwd_a_d, fwd_b_d,
           alu_out_m, result_w, write_reg_w, reg_write_w, stall_d, flush_e,
    input  branch_taken_d, pc_branch_d, ex_valid, ex_rd1, ex_rd2, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_opcode, ex_funct
  );

  modport slave (
    input  valid_d, instr_d, pcplus4_d, zero_ext_d, branch_mode_d, fwd_a_d, fwd_b_d,
           alu_out_m, result_w, write_reg_w, reg_write_w, stall_d, flush_e,
    output branch_taken_d, pc_branch_d, ex_valid, ex_rd1, ex_rd2, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_opcode, ex_funct
  );
endinterface

// File: rtl/id_regfile.sv
// NREGS x WIDTH register file, two combinational reads, one rising-edge write, R0 hardwired to zero.
// A same-cycle write to the read address is returned on the read port (write-through).
module id_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1_i,
  input  logic [AW-1:0]    ra2_i,
  output logic [WIDTH-1:0] rd1_o,
  output logic [WIDTH-1:0] rd2_o,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [WIDTH-1:0] wd_i
);
  logic [WIDTH-1:0] mem_q [NREGS];
  logic             wr_act;

  assign wr_act = we_i && (wa_i != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_act) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = mem_q[ra1_i];
    rd2_o = mem_q[ra2_i];
    if (wr_act && ra1_i == wa_i) rd1_o = wd_i;
    if (wr_act && ra2_i == wa_i) rd2_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
    if (ra2_i == '0) rd2_o = '0;
  end
endmodule

// File: rtl/id_stage_pipelined.sv
// MIPS ID stage: regfile, branch forwarding/compare/target (combinational), ID/EX register (1 cycle, flush > stall).
// Macro ID_BRANCH_EXT_EN adds BLEZ/BGTZ/BLTZ/BGEZ; without it only BEQ/BNE can be taken.
module id_stage_pipelined
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input logic                clk,
  input logic                reset,
  id_stage_pipelined_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]    rs_a, rt_a;
  logic [WIDTH-1:0] rf_rd1, rf_rd2;
  logic [WIDTH-1:0] imm_sext, imm_ext;
  logic [WIDTH-1:0] op_a, op_b;
  branch_mode_t     mode;
  logic             cond;

  id_ex_t           ctl_q, ctl_d;
  logic [WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;

  assign rs_a = AW'(bus.instr_d[25:21]);
  assign rt_a = AW'(bus.instr_d[20:16]);

  id_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1_i (rs_a),
    .ra2_i (rt_a),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2),
    .we_i  (bus.reg_write_w),
    .wa_i  (bus.write_reg_w),
    .wd_i  (bus.result_w)
  );

  assign imm_sext = {{(WIDTH-16){bus.instr_d[15]}}, bus.instr_d[15:0]};
  assign imm_ext  = bus.zero_ext_d ? {{(WIDTH-16){1'b0}}, bus.instr_d[15:0]} : imm_sext;

  // Branch target always uses the sign-extended offset, independent of zero_ext_d.
  assign bus.pc_branch_d = bus.pcplus4_d + (imm_sext << 2);

  always_comb begin
    case (bus.fwd_a_d)
      FWD_M:   op_a = bus.alu_out_m;
      FWD_W:   op_a = bus.result_w;
      default: op_a = rf_rd1;
    endcase
    case (bus.fwd_b_d)
      FWD_M:   op_b = bus.alu_out_m;
      FWD_W:   op_b = bus.result_w;
      default: op_b = rf_rd2;
    endcase
  end

  assign mode = branch_mode_t'(bus.branch_mode_d);

`ifdef ID_BRANCH_EXT_EN
  logic a_neg, a_zero;
  assign a_neg  = op_a[WIDTH-1];
  assign a_zero = (op_a == '0);
`endif

  always_comb begin
    cond = 1'b0;
    case (mode)
      BR_BEQ:  cond = (op_a == op_b);
      BR_BNE:  cond = (op_a != op_b);
`ifdef ID_BRANCH_EXT_EN
      BR_BLEZ: cond = a_neg | a_zero;
      BR_BGTZ: cond = ~a_neg & ~a_zero;
      BR_BLTZ: cond = a_neg;
      BR_BGEZ: cond = ~a_neg;
`endif
      default: cond = 1'b0;
    endcase
  end

  // Not qualified by stall_d: the hazard unit decides whether a taken branch may redirect.
  assign bus.branch_taken_d = bus.valid_d & cond;

  always_comb begin
    ctl_d = ctl_q;
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    imm_d = imm_q;
    if (bus.flush_e) begin
      ctl_d = '0;
      rd1_d = '0;
      rd2_d = '0;
      imm_d = '0;
    end else if (!bus.stall_d) begin
      ctl_d.valid  = bus.valid_d;
      ctl_d.opcode = bus.instr_d[31:26];
      ctl_d.funct  = bus.instr_d[5:0];
      ctl_d.rs     = bus.instr_d[25:21];
      ctl_d.rt     = bus.instr_d[20:16];
      ctl_d.rd     = bus.instr_d[15:11];
      rd1_d        = rf_rd1;
      rd2_d        = rf_rd2;
      imm_d        = imm_ext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_q <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      imm_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      imm_q <= imm_d;
    end
  end

  assign bus.ex_valid  = ctl_q.valid;
  assign bus.ex_opcode = ctl_q.opcode;
  assign bus.ex_funct  = ctl_q.funct;
  assign bus.ex_rs     = AW'(ctl_q.rs);
  assign bus.ex_rt     = AW'(ctl_q.rt);
  assign bus.ex_rd     = AW'(ctl_q.rd);
  assign bus.ex_rd1    = rd1_q;
  assign bus.ex_rd2    = rd2_q;
  assign bus.ex_imm    = imm_q;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed vectors, stall/flush/reset sequences, randomized run against a reference model.
module tb_id_stage_pipelined;
  import mips_pkg::*;

`ifdef ID_BRANCH_EXT_EN
  localparam logic EXT = 1'b1;
`else
  localparam logic EXT = 1'b0;
`endif

  logic clk;
  logic reset;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  id_stage_pipelined_if #(.WIDTH(32), .NREGS(32)) bus ();

  id_stage_pipelined #(.WIDTH(32), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ze;
    logic [2:0]  mode;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] alu;
    logic        exp_tk;
    logic [31:0] exp_pc;
    logic [31:0] exp_imm;
  } vec_t;

  typedef struct packed {
    logic        v;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [5:0]  fn;
  } exex_t;

  vec_t        vt[$];
  logic [31:0] mrf[32];
  exex_t       expx, nxt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic ze, input logic [2:0] mode, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [31:0] alu, input logic tk,
                               input logic [31:0] epc, input logic [31:0] eimm);
    vec_t r;
    r.v = v; r.instr = instr; r.pc = pc; r.ze = ze; r.mode = mode; r.fa = fa; r.fb = fb;
    r.alu = alu; r.exp_tk = tk; r.exp_pc = epc; r.exp_imm = eimm;
    return r;
  endfunction

  // Reference model: architectural register state plus same-cycle writeback visibility.
  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return 32'd0;
    if (bus.reg_write_w && int'(bus.write_reg_w) == a) return bus.result_w;
    return mrf[a];
  endfunction

  function automatic logic [31:0] m_sel(input logic [1:0] f, input int a);
    if (f == 2'd1) return bus.alu_out_m;
    if (f == 2'd2) return bus.result_w;
    return m_read(a);
  endfunction

  function automatic logic m_taken();
    logic signed [31:0] a, b;
    a = m_sel(bus.fwd_a_d, int'(bus.instr_d[25:21]));
    b = m_sel(bus.fwd_b_d, int'(bus.instr_d[20:16]));
    if (!bus.valid_d) return 1'b0;
    case (bus.branch_mode_d)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return EXT && (a <= 0);
      3'd4:    return EXT && (a > 0);
      3'd5:    return EXT && (a < 0);
      3'd6:    return EXT && (a >= 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    bus.valid_d = 0; bus.instr_d = 0; bus.pcplus4_d = 0; bus.zero_ext_d = 0;
    bus.branch_mode_d = 0; bus.fwd_a_d = 0; bus.fwd_b_d = 0; bus.alu_out_m = 0;
    bus.result_w = 0; bus.write_reg_w = 0; bus.reg_write_w = 0; bus.stall_d = 0; bus.flush_e = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #2;
    chk("reset_ex_valid", bus.ex_valid, 0);
    chk("reset_ex_rd1", bus.ex_rd1, 0);
    chk("reset_ex_imm", bus.ex_imm, 0);
    chk("reset_taken", bus.branch_taken_d, 0);
    #10 reset = 1'b1;

    // Write R5 while ID reads R5: bypass delivers it into EX.
    bus.valid_d = 1; bus.instr_d = mk_r(5'd5, 5'd0, 5'd3, FN_ADD);
    bus.reg_write_w = 1; bus.write_reg_w = 5'd5; bus.result_w = 32'h1234;
    tick();
    chk("wt_ex_rd1", bus.ex_rd1, 32'h1234);
    chk("wt_ex_valid", bus.ex_valid, 1);
    chk("wt_ex_rd", bus.ex_rd, 3);
    chk("wt_ex_funct", bus.ex_funct, FN_ADD);

    bus.instr_d = mk_r(5'd0, 5'd5, 5'd0, FN_OR);
    bus.write_reg_w = 5'd0; bus.result_w = 32'hFFFF;
    tick();
    chk("r0_ex_rd1", bus.ex_rd1, 0);
    chk("arr_ex_rd2", bus.ex_rd2, 32'h1234);

    bus.reg_write_w = 1; bus.write_reg_w = 5'd1; bus.result_w = 32'd7; bus.valid_d = 0;
    tick();
    bus.write_reg_w = 5'd2; bus.result_w = 32'd9;
    tick();
    bus.reg_write_w = 0; bus.result_w = 0;

    vt.push_back(mkv(1, mk_i(OP_BEQ, 1, 2, 16'h0004), 32'h1000, 0, 3'd1, 2'd0, 2'd1, 32'd7, 1, 32'h1010, 32'h4));
    vt.push_back(mkv(1, mk_i(OP_BNE, 1, 2, 16'h0004), 32'h1000, 0, 3'd2, 2'd0, 2'd1, 32'd7, 0, 32'h1010, 32'h4));
    vt.push_back(mkv(1, mk_i(OP_BEQ, 1, 2, 16'h0004), 32'h1000, 0, 3'd1, 2'd0, 2'd0, 32'd7, 0, 32'h1010, 32'h4));
    vt.push_back(mkv(1, mk_i(OP_BNE, 1, 2, 16'h0004), 32'h1000, 0, 3'd2, 2'd0, 2'd0, 32'd7, 1, 32'h1010, 32'h4));
    vt.push_back(mkv(1, mk_i(OP_BEQ, 1, 2, 16'h0004), 32'h1000, 0, 3'd1, 2'd3, 2'd1, 32'd7, 1, 32'h1010, 32'h4));
    vt.push_back(mkv(1, mk_i(OP_ADDI, 0, 0, 16'hFFFC), 32'h100, 0, 3'd0, 2'd0, 2'd0, 32'd0, 0, 32'hF0, 32'hFFFFFFFC));
    vt.push_back(mkv(1, mk_i(OP_ADDI, 0, 0, 16'h0001), 32'hFFFFFFFC, 0, 3'd0, 2'd0, 2'd0, 32'd0, 0, 32'h0, 32'h1));
    vt.push_back(mkv(1, mk_i(OP_REGIMM, 1, 0, 16'h0), 32'h2000, 0, 3'd5, 2'd1, 2'd0, 32'h80000000, EXT, 32'h2000, 32'h0));
    vt.push_back(mkv(1, mk_i(OP_REGIMM, 1, 0, 16'h0), 32'h2000, 0, 3'd6, 2'd1, 2'd0, 32'h80000000, 0, 32'h2000, 32'h0));
    vt.push_back(mkv(1, mk_i(OP_BLEZ, 1, 0, 16'h0), 32'h2000, 0, 3'd3, 2'd1, 2'd0, 32'h80000000, EXT, 32'h2000, 32'h0));
    vt.push_back(mkv(1, mk_i(OP_BGTZ, 0, 0, 16'h0), 32'h2000, 0, 3'd4, 2'd0, 2'd0, 32'd0, 0, 32'h2000, 32'h0));
    vt.push_back(mkv(1, mk_i(OP_REGIMM, 0, 0, 16'h0), 32'h2000, 0, 3'd6, 2'd0, 2'd0, 32'd0, EXT, 32'h2000, 32'h0));
    vt.push_back(mkv(1, mk_i(OP_BGTZ, 2, 0, 16'h0), 32'h2000, 0, 3'd4, 2'd0, 2'd0, 32'd0, EXT, 32'h2000, 32'h0));
    vt.push_back(mkv(1, mk_i(OP_ORI, 0, 3, 16'h8001), 32'h20000, 1, 3'd0, 2'd0, 2'd0, 32'd0, 0, 32'h4, 32'h00008001));
    vt.push_back(mkv(1, mk_i(OP_ADDI, 0, 3, 16'h8001), 32'h20000, 0, 3'd0, 2'd0, 2'd0, 32'd0, 0, 32'h4, 32'hFFFF8001));
    vt.push_back(mkv(1, mk_i(OP_BEQ, 1, 2, 16'h0), 32'h40, 0, 3'd7, 2'd0, 2'd1, 32'd7, 0, 32'h40, 32'h0));
    vt.push_back(mkv(0, mk_i(OP_BEQ, 1, 2, 16'h0), 32'h40, 0, 3'd1, 2'd0, 2'd1, 32'd7, 0, 32'h40, 32'h0));

    foreach (vt[i]) begin
      bus.valid_d = vt[i].v; bus.instr_d = vt[i].instr; bus.pcplus4_d = vt[i].pc;
      bus.zero_ext_d = vt[i].ze; bus.branch_mode_d = vt[i].mode;
      bus.fwd_a_d = vt[i].fa; bus.fwd_b_d = vt[i].fb; bus.alu_out_m = vt[i].alu;
      #1;
      chk($sformatf("vec%0d_taken", i), bus.branch_taken_d, vt[i].exp_tk);
      chk($sformatf("vec%0d_pc", i), bus.pc_branch_d, vt[i].exp_pc);
      tick();
      chk($sformatf("vec%0d_ex_imm", i), bus.ex_imm, vt[i].exp_imm);
      chk($sformatf("vec%0d_ex_valid", i), bus.ex_valid, vt[i].v);
    end

    idle();
    bus.valid_d = 1; bus.instr_d = mk_r(5'd1, 5'd2, 5'd7, FN_SUB);
    tick();
    chk("cap_ex_rd1", bus.ex_rd1, 7);
    chk("cap_ex_rd2", bus.ex_rd2, 9);
    bus.stall_d = 1; bus.valid_d = 0; bus.instr_d = mk_r(5'd3, 5'd4, 5'd8, FN_OR);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_ex_valid", bus.ex_valid, 1);
      chk("stall_ex_rd", bus.ex_rd, 7);
      chk("stall_ex_funct", bus.ex_funct, FN_SUB);
      chk("stall_ex_rd2", bus.ex_rd2, 9);
    end
    bus.flush_e = 1;
    tick();
    chk("flush_ex_valid", bus.ex_valid, 0);
    chk("flush_ex_rd1", bus.ex_rd1, 0);
    chk("flush_ex_rd", bus.ex_rd, 0);
    chk("flush_ex_funct", bus.ex_funct, 0);
    bus.flush_e = 0; bus.stall_d = 0; bus.valid_d = 1; bus.instr_d = mk_r(5'd1, 5'd2, 5'd7, FN_SUB);
    tick();
    chk("recap_ex_valid", bus.ex_valid, 1);
    #3 reset = 1'b0;
    #1;
    chk("arst_ex_valid", bus.ex_valid, 0);
    chk("arst_ex_rd1", bus.ex_rd1, 0);
    chk("arst_ex_funct", bus.ex_funct, 0);
    tick();
    reset = 1'b1;
    bus.instr_d = mk_i(OP_BEQ, 1, 0, 16'h0); bus.branch_mode_d = 3'd1;
    #1;
    chk("arst_r1_cleared", bus.branch_taken_d, 1);

    // Randomized run against the reference model, starting from a fresh reset.
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int r = 0; r < 32; r++) mrf[r] = 32'd0;
    expx = '0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins, se, epc;
      logic        wr;
      logic [4:0]  wa;
      logic [31:0] wd;
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      bus.instr_d = ins;
      bus.valid_d = ($urandom_range(0, 3) != 0);
      bus.pcplus4_d = $urandom;
      bus.zero_ext_d = 1'($urandom_range(0, 1));
      bus.branch_mode_d = 3'($urandom_range(0, 7));
      bus.fwd_a_d = 2'($urandom_range(0, 3));
      bus.fwd_b_d = 2'($urandom_range(0, 3));
      bus.alu_out_m = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      bus.result_w = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      bus.write_reg_w = 5'($urandom_range(0, 7));
      bus.reg_write_w = 1'($urandom_range(0, 1));
      bus.stall_d = ($urandom_range(0, 3) == 0);
      bus.flush_e = ($urandom_range(0, 7) == 0);
      #1;
      se = 32'($signed(ins[15:0]));
      epc = bus.pcplus4_d + se * 32'd4;
      chk("rnd_taken", bus.branch_taken_d, m_taken());
      chk("rnd_pc", bus.pc_branch_d, epc);
      nxt = expx;
      if (bus.flush_e) begin
        nxt = '0;
      end else if (!bus.stall_d) begin
        nxt.v   = bus.valid_d;
        nxt.rd1 = m_read(int'(ins[25:21]));
        nxt.rd2 = m_read(int'(ins[20:16]));
        nxt.imm = bus.zero_ext_d ? {16'd0, ins[15:0]} : se;
        nxt.rs  = ins[25:21];
        nxt.rt  = ins[20:16];
        nxt.rd  = ins[15:11];
        nxt.op  = ins[31:26];
        nxt.fn  = ins[5:0];
      end
      wr = bus.reg_write_w && (bus.write_reg_w != 0);
      wa = bus.write_reg_w;
      wd = bus.result_w;
      tick();
      expx = nxt;
      if (wr) mrf[wa] = wd;
      chk("rnd_ex_valid", bus.ex_valid, expx.v);
      chk("rnd_ex_rd1", bus.ex_rd1, expx.rd1);
      chk("rnd_ex_rd2", bus.ex_rd2, expx.rd2);
      chk("rnd_ex_imm", bus.ex_imm, expx.imm);
      chk("rnd_ex_regs", {bus.ex_rs, bus.ex_rt, bus.ex_rd}, {expx.rs, expx.rt, expx.rd});
      chk("rnd_ex_opfn", {bus.ex_opcode, bus.ex_funct}, {expx.op, expx.fn});
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/id_stage_pipelined.md
# id_stage_pipelined

Parametrised instruction-decode stage for the MIPS pipeline. It contains:
- the register file, with write-through bypass;
- branch operand forwarding from the M and W stages;
- a multi-condition branch comparator;
- the branch target adder;
- the ID/EX pipeline register, with stall and flush.

It sits between the IF/ID register and the EX stage. It replaces the combinational decode stage, whose pipeline register and negedge-write register file were external.

## Interface
Parameters:
- WIDTH, 32, datapath width (≥16)
- NREGS, 32, register count (power of two); AW = log2(NREGS)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- valid_d  in  1  instruction in ID is valid
- instr_d  in  32  instruction word
- pcplus4_d  in  WIDTH  PC+4 of the instruction
- zero_ext_d  in  1  1 = zero-extend immediate (andi/ori/xori); 0 = sign-extend
- branch_mode_d  in  3  NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, BLTZ=5, BGEZ=6
- fwd_a_d, fwd_b_d  in  2 each  branch operand source: 0 = regfile, 1 = alu_out_m, 2 = result_w
- alu_out_m  in  WIDTH  M-stage ALU result
- result_w  in  WIDTH  W-stage writeback data
- write_reg_w  in  AW  writeback address
- reg_write_w  in  1  writeback enable
- stall_d  in  1  hold the ID/EX register
- flush_e  in  1  insert a bubble into EX
- branch_taken_d  out  1  combinational branch decision
- pc_branch_d  out  WIDTH  combinational branch target
- ex_valid, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_opcode, ex_funct  out  registered ID/EX bundle; widths 1 / WIDTH / WIDTH / WIDTH / AW / AW / AW / 6 / 6

## Operation
- Fields:
  - rs = instr_d[25:21], rt = [20:16], rd = [15:11], each truncated to AW bits.
  - opcode = [31:26], funct = [5:0].
- Register file:
  - NREGS × WIDTH; two combinational read ports, one write port.
  - Write on the rising edge when reg_write_w and write_reg_w ≠ 0.
  - Register 0 always reads 0.
  - Write-through: if the read address equals write_reg_w, reg_write_w = 1 and the address ≠ 0, the read returns result_w in the same cycle.
- Immediate: instr_d[15:0] is sign- or zero-extended to WIDTH according to zero_ext_d.
- Branch target: pc_branch_d = pcplus4_d + (imm << 2), modulo 2^WIDTH, with carry discarded. Always uses the sign-extended immediate.
- Comparator operands:
  - A and B are selected by fwd_a_d and fwd_b_d.
  - Select value 3 is treated as 0, i.e. regfile.
- Branch conditions:
  - BEQ: A == B. BNE: A ≠ B.
  - BLEZ: A signed ≤ 0. BGTZ: A signed > 0.
  - BLTZ: A signed < 0. BGEZ: A signed ≥ 0.
  - NONE and codes 7+ are never taken.
- branch_taken_d = valid_d & condition. It is not gated by stall_d; the hazard unit owns that.
- ID/EX register update priority:
  - flush_e: ex_valid ← 0; all bundle fields ← 0.
  - else stall_d: hold all fields.
  - else: capture ex_valid ← valid_d, ex_rd1/ex_rd2 ← regfile reads (post-bypass, no M/W forwarding), ex_imm ← extended immediate, and all other fields from the instruction.

## Timing
- Reset: all registers and every ex_* output clear to 0 immediately and asynchronously. Reset may assert mid-operation; no state survives it.
- Combinational outputs are valid in the same cycle as their inputs.
- ID→EX latency is 1 cycle.
- A write on edge N is visible through the array from cycle N+1, and through the bypass during cycle N.
- flush_e and stall_d together: flush wins.
- Simultaneous write and read of the same register: the new data is returned.
- Writes to register 0 are dropped.

## Configuration
- Macro: ID_BRANCH_EXT_EN.
  - Defined: all six branch modes are implemented.
  - Undefined: only BEQ and BNE are implemented; modes 3–6 are never taken and the signed comparator logic is absent.

## Structure
- Package mips_pkg holds:
  - the branch_mode_t enum;
  - forwarding-select constants FWD_RF, FWD_M, FWD_W;
  - opcode/funct localparams;
  - the packed id_ex_t bundle typedef.
- Sub-module id_regfile (parameters WIDTH, NREGS) contains the array, its reset and the write-through bypass.
- The comparator, adder and ID/EX register stay in the top level.

## Test plan
- Reset then write back: deassert reset, write R5 = 0x1234 (reg_write_w = 1).
  - Same cycle: instr rs = 5 → ex_rd1 = 0x1234 after the edge.
  - Write R0 = 0xFFFF → R0 still reads 0.
- BEQ with M-stage forwarding: regfile R1 = 7, R2 = 9, alu_out_m = 7, fwd_b_d = 1, BEQ rs = 1, rt = 2 → branch_taken_d = 1.
  - Same with BNE → 0.
- Branch target: pcplus4 = 0x100, imm = 0xFFFC → pc_branch_d = 0xF0.
  - pcplus4 = 0xFFFFFFFC, imm = 0x0001 → 0x00000000 (wrap).
- Extended branches (ID_BRANCH_EXT_EN defined): A = 0x80000000 → BLTZ taken, BGEZ not taken, BLEZ taken; A = 0 → BGTZ not taken, BGEZ taken.
  - Without the macro: all four are never taken.
- Stall and flush: stall_d held for 2 cycles → ex_* unchanged.
  - flush_e together with stall_d → ex_valid = 0 and all fields zero.
  - Async reset asserted mid-cycle → ex_* = 0 before the next edge.
- Immediate extension: imm = 0x8001 with zero_ext_d = 1 → ex_imm = 0x00008001; with zero_ext_d = 0 → 0xFFFF8001.
